// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction-fetch front end. It owns the PC and a DEPTH-entry prefetch
//   FIFO that sits between instruction memory and decode. While the queue has
//   space, it fetches one word per cycle. It presents the oldest entry to
//   decode over a valid/ready handshake. A redirect discards all queued work
//   and restarts fetch at a new PC.
//
// Parameters
//   WIDTH    address / instruction width in bits (>= 8)
//   DEPTH    queue entries, power of two, >= 2
//   RESET_PC PC loaded on reset (low two bits zero)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset (has priority over redirect)
//   imem_addr    fetch address, always the PC register
//   imem_en      high when the word on imem_rdata is enqueued this cycle
//   imem_rdata   instruction at imem_addr (combinational, same cycle)
//   redirect     flush the queue and restart fetch at redirect_pc
//   redirect_pc  new PC, bits [1:0] forced to zero
//   valid_d      queue head is valid
//   ready_d      decode accepts the head this cycle
//   instr_d      head instruction, zero when not valid
//   pc_plus4_d   head fetch address + 4, zero when not valid
//   count        number of occupied entries
module prefetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH-1:0]           imem_addr,
  output logic                       imem_en,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       valid_d,
  input  logic                       ready_d,
  output logic [WIDTH-1:0]           instr_d,
  output logic [WIDTH-1:0]           pc_plus4_d,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] pc;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    occupancy;

  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_pc4   [DEPTH];

  logic             pop;
  logic             fetch;
  logic [WIDTH-1:0] pc_next_seq;

  // The two alignment bits of a redirect target are discarded by design.
  logic             unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign pc_next_seq = pc + WIDTH'(4);

  // A pop frees a slot in the same cycle, so a full queue can still accept a
  // fetch while decode drains it. A redirect voids both the pop and the fetch.
  // Reset also voids the fetch, so imem_en stays low while reset is held.
  always_comb begin
    pop   = 1'b0;
    fetch = 1'b0;
    if (!reset && !redirect) begin
      pop   = valid_d & ready_d;
      fetch = (occupancy < FULL_COUNT) | pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (redirect) begin
      pc        <= {redirect_pc[WIDTH-1:2], 2'b00};
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (fetch) begin
        pc   <= pc_next_seq;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      occupancy <= occupancy + CW'(fetch) - CW'(pop);
    end
  end

  // Storage is not reset. Every read is gated by valid_d.
  always_ff @(posedge clk) begin
    if (fetch) begin
      mem_instr[tail] <= imem_rdata;
      mem_pc4[tail]   <= pc_next_seq;
    end
  end

  always_comb begin
    instr_d    = '0;
    pc_plus4_d = '0;
    if (valid_d) begin
      instr_d    = mem_instr[head];
      pc_plus4_d = mem_pc4[head];
    end
  end

  assign valid_d   = (occupancy != '0);
  assign imem_en   = fetch;
  assign imem_addr = pc;
  assign count     = occupancy;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue
//   Drives two instances of prefetch_queue from shared controls:
//     w32 - WIDTH=32, RESET_PC=0
//     w8  - WIDTH=8,  RESET_PC=F8 (exercises address wrap)
//   Both instances are compared every cycle against a shift-array reference
//   model. A table of fixed vectors, a wrap sequence and a random phase are
//   applied on top of that.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        ready_d;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  logic [31:0] a_addr, a_rdata, a_instr, a_pc4;
  logic        a_en, a_valid;
  logic [2:0]  a_count;
  logic [7:0]  b_addr, b_rdata, b_instr, b_pc4;
  logic        b_en, b_valid;
  logic [2:0]  b_count;

  assign a_rdata = a_addr ^ 32'hA5A5_0000;
  assign b_rdata = b_addr ^ 8'h5A;

  prefetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_w32 (
    .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_en(a_en),
    .imem_rdata(a_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_d(a_valid), .ready_d(ready_d), .instr_d(a_instr),
    .pc_plus4_d(a_pc4), .count(a_count)
  );

  prefetch_queue #(.WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) u_w8 (
    .clk(clk), .reset(reset), .imem_addr(b_addr), .imem_en(b_en),
    .imem_rdata(b_rdata), .redirect(redirect), .redirect_pc(redirect_pc[7:0]),
    .valid_d(b_valid), .ready_d(ready_d), .instr_d(b_instr),
    .pc_plus4_d(b_pc4), .count(b_count)
  );

  logic [1:0][31:0] o_addr, o_instr, o_pc4, o_count;
  logic [1:0]       o_en, o_valid;

  assign o_addr[0]  = a_addr;
  assign o_addr[1]  = {24'b0, b_addr};
  assign o_instr[0] = a_instr;
  assign o_instr[1] = {24'b0, b_instr};
  assign o_pc4[0]   = a_pc4;
  assign o_pc4[1]   = {24'b0, b_pc4};
  assign o_count[0] = {29'b0, a_count};
  assign o_count[1] = {29'b0, b_count};
  assign o_en       = {b_en, a_en};
  assign o_valid    = {b_valid, a_valid};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue kept as a shift array, head always at index 0.
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2][4];
  logic [31:0] m_pc4   [2][4];
  int          m_n     [2];

  function automatic logic [31:0] mask_of(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] xor_of(int k);
    return (k == 0) ? 32'hA5A5_0000 : 32'h0000_005A;
  endfunction

  function automatic logic [31:0] reset_pc_of(int k);
    return (k == 0) ? 32'h0 : 32'hF8;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int k, input bit rst, input bit rd, input bit rdy);
    string tag;
    bit    exp_en;
    tag    = (k == 0) ? "w32" : "w8";
    exp_en = !rst && !rd && ((m_n[k] < 4) || (m_n[k] > 0 && rdy));
    check_output({tag, " addr"},  o_addr[k], m_pc[k]);
    check_output({tag, " en"},    {31'b0, o_en[k]}, {31'b0, exp_en});
    check_output({tag, " valid"}, {31'b0, o_valid[k]}, (m_n[k] > 0) ? 32'd1 : 32'd0);
    check_output({tag, " count"}, o_count[k], 32'(m_n[k]));
    check_output({tag, " instr"}, o_instr[k], (m_n[k] > 0) ? m_instr[k][0] : 32'h0);
    check_output({tag, " pc4"},   o_pc4[k],   (m_n[k] > 0) ? m_pc4[k][0]   : 32'h0);
  endtask

  task automatic model_step(input int k, input bit rst, input bit rd,
                            input logic [31:0] rpc, input bit rdy);
    bit pop, fetch;
    if (rst) begin
      m_pc[k] = reset_pc_of(k);
      m_n[k]  = 0;
    end else if (rd) begin
      m_pc[k] = rpc & mask_of(k) & ~32'h3;
      m_n[k]  = 0;
    end else begin
      pop   = (m_n[k] > 0) && rdy;
      fetch = (m_n[k] < 4) || pop;
      if (pop) begin
        for (int i = 0; i < 3; i++) begin
          m_instr[k][i] = m_instr[k][i+1];
          m_pc4[k][i]   = m_pc4[k][i+1];
        end
        m_n[k]--;
      end
      if (fetch) begin
        m_instr[k][m_n[k]] = m_pc[k] ^ xor_of(k);
        m_pc4[k][m_n[k]]   = (m_pc[k] + 32'd4) & mask_of(k);
        m_n[k]++;
        m_pc[k] = (m_pc[k] + 32'd4) & mask_of(k);
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check just after, then
  // advance the model to the state the coming rising edge produces.
  task automatic apply_stimulus(input bit rst, input bit rd, input logic [31:0] rpc,
                                input bit rdy, input bit chk);
    @(negedge clk);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    ready_d     = rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (chk) check_model(k, rst, rd, rdy);
      model_step(k, rst, rd, rpc, rdy);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          rd;
    logic [31:0] rpc;
    bit          rdy;
    logic [31:0] addr;
    bit          en;
    bit          vld;
    logic [31:0] instr;
    logic [31:0] pc4;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rd, logic [31:0] rpc, bit rdy,
                              logic [31:0] addr, bit en, bit vld,
                              logic [31:0] instr, logic [31:0] pc4, int cnt);
    vec_t v;
    v.rst = rst; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.addr = addr; v.en = en; v.vld = vld; v.instr = instr; v.pc4 = pc4; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl [31];

  initial begin
    // rst rd rpc rdy | addr en vld instr pc4 count   (w32 instance)
    tbl[0]  = mk(1, 0, 32'h0,   0, 32'h000, 0, 0, 32'h0,         32'h0,   0);
    tbl[1]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 0, 32'h0,         32'h0,   0);
    tbl[2]  = mk(0, 0, 32'h0,   0, 32'h004, 1, 1, 32'hA5A5_0000, 32'h004, 1);
    tbl[3]  = mk(0, 0, 32'h0,   0, 32'h008, 1, 1, 32'hA5A5_0000, 32'h004, 2);
    tbl[4]  = mk(0, 0, 32'h0,   0, 32'h00C, 1, 1, 32'hA5A5_0000, 32'h004, 3);
    tbl[5]  = mk(0, 0, 32'h0,   0, 32'h010, 0, 1, 32'hA5A5_0000, 32'h004, 4);
    tbl[6]  = mk(0, 0, 32'h0,   0, 32'h010, 0, 1, 32'hA5A5_0000, 32'h004, 4);
    tbl[7]  = mk(0, 0, 32'h0,   1, 32'h010, 1, 1, 32'hA5A5_0000, 32'h004, 4);
    tbl[8]  = mk(0, 0, 32'h0,   0, 32'h014, 0, 1, 32'hA5A5_0004, 32'h008, 4);
    tbl[9]  = mk(0, 0, 32'h0,   1, 32'h014, 1, 1, 32'hA5A5_0004, 32'h008, 4);
    tbl[10] = mk(0, 0, 32'h0,   1, 32'h018, 1, 1, 32'hA5A5_0008, 32'h00C, 4);
    tbl[11] = mk(0, 1, 32'h200, 0, 32'h01C, 0, 1, 32'hA5A5_000C, 32'h010, 4);
    tbl[12] = mk(0, 0, 32'h0,   0, 32'h200, 1, 0, 32'h0,         32'h0,   0);
    tbl[13] = mk(0, 0, 32'h0,   0, 32'h204, 1, 1, 32'hA5A5_0200, 32'h204, 1);
    tbl[14] = mk(0, 0, 32'h0,   0, 32'h208, 1, 1, 32'hA5A5_0200, 32'h204, 2);
    tbl[15] = mk(0, 1, 32'h103, 1, 32'h20C, 0, 1, 32'hA5A5_0200, 32'h204, 3);
    tbl[16] = mk(0, 0, 32'h0,   1, 32'h100, 1, 0, 32'h0,         32'h0,   0);
    tbl[17] = mk(0, 0, 32'h0,   1, 32'h104, 1, 1, 32'hA5A5_0100, 32'h104, 1);
    tbl[18] = mk(0, 0, 32'h0,   1, 32'h108, 1, 1, 32'hA5A5_0104, 32'h108, 1);
    tbl[19] = mk(0, 1, 32'h300, 1, 32'h10C, 0, 1, 32'hA5A5_0108, 32'h10C, 1);
    tbl[20] = mk(0, 1, 32'h404, 1, 32'h300, 0, 0, 32'h0,         32'h0,   0);
    tbl[21] = mk(0, 0, 32'h0,   1, 32'h404, 1, 0, 32'h0,         32'h0,   0);
    tbl[22] = mk(0, 0, 32'h0,   1, 32'h408, 1, 1, 32'hA5A5_0404, 32'h408, 1);
    tbl[23] = mk(0, 0, 32'h0,   0, 32'h40C, 1, 1, 32'hA5A5_0408, 32'h40C, 1);
    tbl[24] = mk(0, 0, 32'h0,   0, 32'h410, 1, 1, 32'hA5A5_0408, 32'h40C, 2);
    tbl[25] = mk(0, 0, 32'h0,   0, 32'h414, 1, 1, 32'hA5A5_0408, 32'h40C, 3);
    tbl[26] = mk(0, 0, 32'h0,   0, 32'h418, 0, 1, 32'hA5A5_0408, 32'h40C, 4);
    tbl[27] = mk(1, 1, 32'h500, 1, 32'h418, 0, 1, 32'hA5A5_0408, 32'h40C, 4);
    tbl[28] = mk(0, 0, 32'h0,   1, 32'h000, 1, 0, 32'h0,         32'h0,   0);
    tbl[29] = mk(0, 0, 32'h0,   1, 32'h004, 1, 1, 32'hA5A5_0000, 32'h004, 1);
    tbl[30] = mk(0, 0, 32'h0,   1, 32'h008, 1, 1, 32'hA5A5_0004, 32'h008, 1);

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; ready_d = 1'b0;
    apply_stimulus(1, 0, 32'h0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0);

    for (int i = 0; i < 31; i++) begin
      apply_stimulus(tbl[i].rst, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, 1);
      check_output($sformatf("row%0d addr", i),  a_addr, tbl[i].addr);
      check_output($sformatf("row%0d en", i),    {31'b0, a_en}, {31'b0, tbl[i].en});
      check_output($sformatf("row%0d valid", i), {31'b0, a_valid}, {31'b0, tbl[i].vld});
      check_output($sformatf("row%0d instr", i), a_instr, tbl[i].instr);
      check_output($sformatf("row%0d pc4", i),   a_pc4, tbl[i].pc4);
      check_output($sformatf("row%0d count", i), {29'b0, a_count}, 32'(tbl[i].cnt));
    end

    // Narrow instance: fetch F8, FC, 00, 04 and carry the wrapped pc+4.
    apply_stimulus(1, 0, 32'h0, 0, 1);
    apply_stimulus(0, 0, 32'h0, 0, 1);
    check_output("wrap addr F8", {24'b0, b_addr}, 32'hF8);
    apply_stimulus(0, 0, 32'h0, 0, 1);
    check_output("wrap addr FC", {24'b0, b_addr}, 32'hFC);
    check_output("wrap head F8 instr", {24'b0, b_instr}, 32'hA2);
    check_output("wrap head F8 pc4", {24'b0, b_pc4}, 32'hFC);
    apply_stimulus(0, 0, 32'h0, 1, 1);
    check_output("wrap addr 00", {24'b0, b_addr}, 32'h00);
    check_output("wrap en", {31'b0, b_en}, 32'd1);
    apply_stimulus(0, 0, 32'h0, 1, 1);
    check_output("wrap addr 04", {24'b0, b_addr}, 32'h04);
    check_output("wrap head FC instr", {24'b0, b_instr}, 32'hA6);
    check_output("wrap head FC pc4", {24'b0, b_pc4}, 32'h00);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                     $urandom, $urandom_range(0, 2) != 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
